// File: rtl/blk_rd_sched.sv
// Block read scheduler: round-robin arbitration of per-port block read requests onto a
// single word-wide memory read path. One grant streams 1..2**TIMES_WIDTH words, then a
// one-cycle completion pulse returns the port's ownership.
module blk_rd_sched #(
  parameter int unsigned PORTNUM        = 16,
  parameter int unsigned BLK_ADDR_WIDTH = 10,
  parameter int unsigned TIMES_WIDTH    = 4
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [PORTNUM-1:0]                    i_req_vld,
  input  logic [PORTNUM*BLK_ADDR_WIDTH-1:0]     i_req_addr,
  input  logic [PORTNUM-1:0]                    i_req_last,
  input  logic [PORTNUM*TIMES_WIDTH-1:0]        i_req_times,
  input  logic                                  i_mem_stall,
  output logic [PORTNUM-1:0]                    o_gnt,
  output logic [PORTNUM-1:0]                    o_r_done,
  output logic                                  o_mem_rd_en,
  output logic [BLK_ADDR_WIDTH+TIMES_WIDTH-1:0] o_mem_addr,
  output logic [$clog2(PORTNUM)-1:0]            o_mem_port,
  output logic                                  o_mem_last_word
);

  localparam int unsigned PW  = $clog2(PORTNUM);
  localparam int unsigned BAW = BLK_ADDR_WIDTH;
  localparam int unsigned TW  = TIMES_WIDTH;
  localparam int unsigned MAW = BAW + TW;

  typedef enum logic [1:0] {StIdle, StRead, StDone} state_e;

  // State and latched grant fields
  state_e          r_state, w_state_nxt;
  logic [PW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [PW-1:0]   r_win, w_win_nxt;
  logic [BAW-1:0]  r_addr, w_addr_nxt;
  logic            r_last, w_last_nxt;
  logic [TW-1:0]   r_times, w_times_nxt;
  // One extra bit so a full block count (2**TW) is representable without aliasing to 0
  logic [TW:0]     r_idx, w_idx_nxt;

  // Registered outputs
  logic [PORTNUM-1:0] r_gnt, w_gnt_nxt;
  logic [PORTNUM-1:0] r_r_done, w_r_done_nxt;
  logic               r_rd_en, w_rd_en_nxt;
  logic [MAW-1:0]     r_mem_addr, w_mem_addr_nxt;
  logic [PW-1:0]      r_mem_port, w_mem_port_nxt;
  logic               r_last_word, w_last_word_nxt;

  // Per-port field views
  logic [BAW-1:0] w_addr_arr  [PORTNUM];
  logic [TW-1:0]  w_times_arr [PORTNUM];

  for (genvar g = 0; g < PORTNUM; g++) begin : g_slice
    assign w_addr_arr[g]  = i_req_addr[g*BAW +: BAW];
    assign w_times_arr[g] = i_req_times[g*TW +: TW];
  end

  // The requester still holds i_req_vld during its o_r_done cycle (which is the IDLE cycle),
  // so that port is masked to avoid a spurious re-grant on a stale request.
  logic [PORTNUM-1:0] w_req_m;
  logic               w_any;
  logic [PW-1:0]      w_win;
  logic [TW:0]        w_cnt_in;
  logic [TW:0]        w_cnt;
  logic [TW:0]        w_idx_inc;

  assign w_req_m   = i_req_vld & ~r_r_done;
  assign w_cnt_in  = i_req_last[w_win] ? ({1'b0, w_times_arr[w_win]} + (TW+1)'(1))
                                       : {1'b1, {TW{1'b0}}};
  assign w_cnt     = r_last ? ({1'b0, r_times} + (TW+1)'(1)) : {1'b1, {TW{1'b0}}};
  assign w_idx_inc = r_idx + (TW+1)'(1);

  // Round-robin search: first requesting port at or above rr_ptr, wrapping
  always_comb begin
    int unsigned j;
    logic [PW-1:0] idx;
    j     = 0;
    idx   = '0;
    w_any = 1'b0;
    w_win = '0;
    // Descending scan so the smallest offset from rr_ptr is written last and wins
    for (int i = PORTNUM - 1; i >= 0; i--) begin
      j = int'(r_rr_ptr) + i;
      if (j >= PORTNUM) j = j - PORTNUM;
      idx = PW'(j);
      if (w_req_m[idx]) begin
        w_any = 1'b1;
        w_win = idx;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_win_nxt       = r_win;
    w_addr_nxt      = r_addr;
    w_last_nxt      = r_last;
    w_times_nxt     = r_times;
    w_idx_nxt       = r_idx;
    w_gnt_nxt       = '0;
    w_r_done_nxt    = '0;
    w_rd_en_nxt     = 1'b0;
    w_mem_addr_nxt  = '0;
    w_mem_port_nxt  = '0;
    w_last_word_nxt = 1'b0;

    case (r_state)
      StIdle: begin
        if (w_any) begin
          w_win_nxt        = w_win;
          w_addr_nxt       = w_addr_arr[w_win];
          w_last_nxt       = i_req_last[w_win];
          w_times_nxt      = w_times_arr[w_win];
          w_idx_nxt        = '0;
          w_gnt_nxt[w_win] = 1'b1;
          w_state_nxt      = StRead;
          // Word 0 goes out alongside the grant so the first strobe meets the grant cycle
          if (!i_mem_stall) begin
            w_rd_en_nxt    = 1'b1;
            w_mem_addr_nxt = {w_addr_arr[w_win], {TW{1'b0}}};
            w_mem_port_nxt = w_win;
            w_idx_nxt      = (TW+1)'(1);
            if (w_cnt_in == (TW+1)'(1)) begin
              w_last_word_nxt = 1'b1;
              w_state_nxt     = StDone;
            end
          end
        end
      end
      StRead: begin
        if (!i_mem_stall) begin
          w_rd_en_nxt    = 1'b1;
          w_mem_addr_nxt = {r_addr, r_idx[TW-1:0]};
          w_mem_port_nxt = r_win;
          w_idx_nxt      = w_idx_inc;
          if (w_idx_inc == w_cnt) begin
            w_last_word_nxt = 1'b1;
            w_state_nxt     = StDone;
          end
        end
      end
      StDone: begin
        w_r_done_nxt[r_win] = 1'b1;
        w_rr_ptr_nxt        = (r_win == PW'(PORTNUM - 1)) ? '0 : r_win + PW'(1);
        w_state_nxt         = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State register with synchronous reset; reset aborts any grant in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_rr_ptr    <= '0;
      r_win       <= '0;
      r_addr      <= '0;
      r_last      <= 1'b0;
      r_times     <= '0;
      r_idx       <= '0;
      r_gnt       <= '0;
      r_r_done    <= '0;
      r_rd_en     <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_port  <= '0;
      r_last_word <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_win       <= w_win_nxt;
      r_addr      <= w_addr_nxt;
      r_last      <= w_last_nxt;
      r_times     <= w_times_nxt;
      r_idx       <= w_idx_nxt;
      r_gnt       <= w_gnt_nxt;
      r_r_done    <= w_r_done_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_port  <= w_mem_port_nxt;
      r_last_word <= w_last_word_nxt;
    end
  end

  assign o_gnt           = r_gnt;
  assign o_r_done        = r_r_done;
  assign o_mem_rd_en     = r_rd_en;
  assign o_mem_addr      = r_mem_addr;
  assign o_mem_port      = r_mem_port;
  assign o_mem_last_word = r_last_word;

endmodule

// File: tb/tb_blk_rd_sched.sv
// Directed self-checking bench for blk_rd_sched.
module tb_blk_rd_sched;

  localparam int NP  = 16;
  localparam int BAW = 10;
  localparam int TW  = 4;
  localparam int AW  = NP * BAW;
  localparam int TWA = NP * TW;

  logic            clk;
  logic            i_rst;
  logic [NP-1:0]   i_req_vld;
  logic [AW-1:0]   i_req_addr;
  logic [NP-1:0]   i_req_last;
  logic [TWA-1:0]  i_req_times;
  logic            i_mem_stall;
  logic [NP-1:0]   o_gnt;
  logic [NP-1:0]   o_r_done;
  logic            o_mem_rd_en;
  logic [BAW+TW-1:0] o_mem_addr;
  logic [3:0]      o_mem_port;
  logic            o_mem_last_word;

  int n_checks = 0;
  int n_errs   = 0;

  blk_rd_sched #(
    .PORTNUM       (NP),
    .BLK_ADDR_WIDTH(BAW),
    .TIMES_WIDTH   (TW)
  ) u_dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_req_vld      (i_req_vld),
    .i_req_addr     (i_req_addr),
    .i_req_last     (i_req_last),
    .i_req_times    (i_req_times),
    .i_mem_stall    (i_mem_stall),
    .o_gnt          (o_gnt),
    .o_r_done       (o_r_done),
    .o_mem_rd_en    (o_mem_rd_en),
    .o_mem_addr     (o_mem_addr),
    .o_mem_port     (o_mem_port),
    .o_mem_last_word(o_mem_last_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then stable and new inputs land before the next edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input int addr, input bit last, input int times);
    i_req_addr  &= ~(AW'({BAW{1'b1}}) << (p * BAW));
    i_req_addr  |= AW'(addr) << (p * BAW);
    i_req_last   = (i_req_last & ~(NP'(1) << p)) | (NP'(last) << p);
    i_req_times &= ~(TWA'({TW{1'b1}}) << (p * TW));
    i_req_times |= TWA'(times) << (p * TW);
  endtask

  // One complete grant for port p; other requests are dropped after the grant
  task automatic xfer(input string tag, input int p, input int addr, input bit last,
                      input int times, input int stall_at, input int stall_len);
    int n, k, cyc, strays, stall_left;
    bit done_seen;
    n          = last ? times + 1 : 16;
    k          = 0;
    cyc        = 0;
    strays     = 0;
    stall_left = 0;
    done_seen  = 1'b0;
    set_port(p, addr, last, times);
    i_req_vld |= NP'(1) << p;
    while (!done_seen && cyc < 80) begin
      step();
      cyc++;
      if (cyc == 1) begin
        check({tag, "_gnt"}, 32'(o_gnt), 32'(NP'(1) << p));
        i_req_vld = NP'(1) << p;
      end else if (o_gnt != '0) begin
        strays++;
      end
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) i_mem_stall = 1'b0;
      end
      if (o_mem_rd_en) begin
        check({tag, "_addr"}, 32'(o_mem_addr), 32'((addr << TW) | k));
        check({tag, "_port"}, 32'(o_mem_port), 32'(p));
        check({tag, "_lastw"}, 32'(o_mem_last_word), 32'(k == n - 1));
        if (k == stall_at && stall_len > 0) begin
          i_mem_stall = 1'b1;
          stall_left  = stall_len;
        end
        k++;
      end
      if (o_r_done != '0) begin
        done_seen = 1'b1;
        check({tag, "_done"}, 32'(o_r_done), 32'(NP'(1) << p));
        check({tag, "_done_rden"}, 32'(o_mem_rd_en), 32'(0));
      end
    end
    check({tag, "_done_seen"}, 32'(done_seen), 32'(1));
    check({tag, "_words"}, 32'(k), 32'(n));
    check({tag, "_done_cyc"}, 32'(cyc), 32'(n + 1 + stall_len));
    check({tag, "_stray_gnt"}, 32'(strays), 32'(0));
    // Requester still holds its request during the o_r_done cycle; no re-grant allowed
    step();
    check({tag, "_no_regrant"}, 32'(o_gnt), 32'(0));
    i_req_vld = '0;
    step();
  endtask

  initial begin
    int order [4];
    int g, cyc, k, strobes, dones;
    order = '{1, 2, 15, 1};

    i_rst       = 1'b1;
    i_req_vld   = '0;
    i_req_addr  = '0;
    i_req_last  = '0;
    i_req_times = '0;
    i_mem_stall = 1'b0;

    // Ports 1, 2, 15 request continuously from reset, one word each
    set_port(1, 'h011, 1'b1, 0);
    set_port(2, 'h022, 1'b1, 0);
    set_port(15, 'h03F, 1'b1, 0);
    i_req_vld = (NP'(1) << 1) | (NP'(1) << 2) | (NP'(1) << 15);
    step();
    step();
    check("rst_gnt", 32'(o_gnt), 32'(0));
    check("rst_done", 32'(o_r_done), 32'(0));
    check("rst_rden", 32'(o_mem_rd_en), 32'(0));
    check("rst_addr", 32'(o_mem_addr), 32'(0));
    check("rst_port", 32'(o_mem_port), 32'(0));
    check("rst_lastw", 32'(o_mem_last_word), 32'(0));
    i_rst = 1'b0;

    g   = 0;
    cyc = 0;
    while (g < 4 && cyc < 60) begin
      step();
      cyc++;
      if (o_gnt != '0) begin
        check("rr_order", 32'(o_gnt), 32'(NP'(1) << order[g]));
        check("rr_port", 32'(o_mem_port), 32'(order[g]));
        g++;
      end
    end
    check("rr_grants", 32'(g), 32'(4));
    i_req_vld = '0;
    repeat (5) step();

    // Idle with no request: outputs stay quiet
    check("idle_gnt", 32'(o_gnt), 32'(0));
    check("idle_rden", 32'(o_mem_rd_en), 32'(0));
    check("idle_done", 32'(o_r_done), 32'(0));

    xfer("p3_full", 3, 'h005, 1'b0, 0, -1, 0);
    xfer("p0_t2", 0, 'h3FF, 1'b1, 2, -1, 0);
    xfer("p7_t0", 7, 'h012, 1'b1, 0, -1, 0);
    xfer("p15_t15", 15, 'h2AB, 1'b1, 15, -1, 0);
    xfer("p4_stall", 4, 'h0C3, 1'b0, 0, 4, 2);

    // Port 5 full block, reset lands while word 7 is on the bus
    set_port(5, 'h155, 1'b0, 0);
    i_req_vld = NP'(1) << 5;
    k   = 0;
    cyc = 0;
    while (k < 8 && cyc < 40) begin
      step();
      cyc++;
      if (o_mem_rd_en) k++;
    end
    check("abort_reach_w7", 32'(k), 32'(8));
    i_rst = 1'b1;
    step();
    i_rst     = 1'b0;
    i_req_vld = '0;
    check("abort_rden", 32'(o_mem_rd_en), 32'(0));
    check("abort_addr", 32'(o_mem_addr), 32'(0));
    check("abort_done", 32'(o_r_done), 32'(0));
    strobes = 0;
    dones   = 0;
    repeat (20) begin
      step();
      if (o_mem_rd_en) strobes++;
      if (o_r_done != '0) dones++;
    end
    check("abort_strobes", 32'(strobes), 32'(0));
    check("abort_no_done", 32'(dones), 32'(0));

    // Ports 2 and 6 together: rr_ptr back at 0 so port 2 must win
    set_port(6, 'h066, 1'b1, 1);
    i_req_vld = NP'(1) << 6;
    xfer("post_rst_p2", 2, 'h2A2, 1'b1, 0, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/blk_rd_sched.md
BLK_RD_SCHED -- requirements
Module: blk_rd_sched

Interface
REQ-001 Parameter PORTNUM, default 16, number of output-port requesters sharing the cell read path.
REQ-002 Parameter BLK_ADDR_WIDTH, default 10, block address width.
REQ-003 Parameter TIMES_WIDTH, default 4, word-count width; a full block is 2**TIMES_WIDTH (16) 32-bit words.
REQ-004 i_clk  input  1  sole clock; one clock, reset is synchronous and active-high.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_req_vld  input  PORTNUM  per-port read request, level; held until that port's o_r_done.
REQ-007 i_req_addr  input  PORTNUM*BLK_ADDR_WIDTH  per-port block address, port p at slice p; stable while request held.
REQ-008 i_req_last  input  PORTNUM  per-port flag: requested block is the last block of the packet.
REQ-009 i_req_times  input  PORTNUM*TIMES_WIDTH  per-port words-minus-one for a last block; ignored when i_req_last=0.
REQ-010 i_mem_stall  input  1  memory cannot accept a read this cycle.
REQ-011 o_gnt  output  PORTNUM  one-hot grant pulse.
REQ-012 o_r_done  output  PORTNUM  one-hot completion pulse.
REQ-013 o_mem_rd_en  output  1  word read strobe.
REQ-014 o_mem_addr  output  BLK_ADDR_WIDTH+TIMES_WIDTH  word address = {block address, word index}.
REQ-015 o_mem_port  output  $clog2(PORTNUM)  owning port of current read word.
REQ-016 o_mem_last_word  output  1  high with the final o_mem_rd_en of a grant.

Function
REQ-017 States: IDLE, READ, DONE; all outputs registered.
REQ-018 IDLE: if any i_req_vld, winner = first set bit searching upward from rr_ptr, wrapping modulo PORTNUM; latch winner's addr, last, times; clear word index to 0; pulse o_gnt[winner] next cycle; go READ.
REQ-019 IDLE with no request: remain IDLE, all outputs 0.
REQ-020 Word count per grant: 2**TIMES_WIDTH when latched last=0; latched times+1 when last=1 (times=0 gives 1 word, all-ones gives full block).
REQ-021 READ, i_mem_stall=0: next cycle o_mem_rd_en=1, o_mem_addr={latched addr, index}, o_mem_port=winner; index increments.
REQ-022 READ, i_mem_stall=1: next cycle o_mem_rd_en=0, index holds, no word skipped or repeated.
REQ-023 The issue of the final word sets o_mem_last_word=1 on that same strobe; FSM goes DONE.
REQ-024 DONE lasts exactly one cycle: o_r_done[winner]=1, rr_ptr <= (winner+1) mod PORTNUM, next state IDLE.
REQ-025 Latency: request in IDLE at cycle t -> o_gnt at t+1, first rd_en at t+1 when no stall, N words with no stall -> o_r_done at t+N+1.
REQ-026 Requester deasserts i_req_vld on the cycle after o_r_done; IDLE re-arbitrates the cycle after DONE, no dead cycle beyond that.
REQ-027 Requests arriving or dropping during READ/DONE do not affect the current grant; only latched values are used.
REQ-028 Simultaneous requests: exactly one grant; every continuously requesting port is granted within PORTNUM grants.
REQ-029 rr_ptr wrap: winner PORTNUM-1 sets rr_ptr to 0.
REQ-030 Index counter is TIMES_WIDTH+1 bits wide so a full block terminates without wrap alias.
REQ-031 o_gnt, o_r_done, o_mem_rd_en never assert on more than one bit / in IDLE.

Reset
REQ-032 i_rst sampled high: next cycle state IDLE, rr_ptr 0, index 0, latched fields 0, all outputs 0.
REQ-033 Reset mid-READ aborts the grant with no o_r_done; reset dominates all other inputs.

Verification
REQ-034 Port 3 req, last=0, addr 0x05, no stall -> o_gnt[3] one cycle, 16 strobes addr 0x050..0x05F, last_word on 0x05F, o_r_done[3] next cycle.
REQ-035 Port 0 req, last=1, times=2, addr 0x3FF -> 3 strobes 0x3FF0..0x3FF2, last_word on 0x3FF2, o_r_done[0].
REQ-036 Ports 1,2,15 held continuously from reset -> grant order 1,2,15,1; rr_ptr wraps 15->0.
REQ-037 Stall high for 2 cycles after word 4 of a full block -> rd_en low 2 cycles, resumes at word 5, 16 strobes total, done delayed 2 cycles.
REQ-038 i_rst high during word 7 of port 5's grant -> no further strobes, no o_r_done[5], next request grant from rr_ptr 0.
